// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit_if
//  Description : Handshake and HI/LO bus between the EX stage and the
//                iterative multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    // Pipeline / hazard side: issues requests, observes status and HI/LO.
    modport master (
        output start, op, src_a, src_b, flush, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    // Multiply/divide unit side.
    modport slave (
        input  start, op, src_a, src_b, flush, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative 32-bit MULT/MULTU/DIV/DIVU unit owning HI/LO.
//                32 shift-add / restoring-division iterations followed by a
//                single sign-fix cycle (34-cycle latency).
//                Optional macro MDU_SIGNED_EN enables signed MULT/DIV; when
//                undefined, MULT acts as MULTU and DIV as DIVU.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit (
    input  wire logic          clk,
    input  wire logic          rst,
    mul_div_unit_if.slave      bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_dbz;
    logic [31:0] r_opnd;      // |A| for multiply (addend), |B| for divide (divisor)
    logic [63:0] r_acc;       // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic        r_busy;
    logic        r_done;
    logic        r_dbz_out;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic        w_neg_q;     // product / quotient must be negated
    logic        w_neg_r;     // remainder must be negated
    logic        w_neg_q_in;
    logic        w_neg_r_in;

    assign w_accept = (r_state == c_IDLE) && bus.start && !bus.flush;

`ifdef MDU_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;
    logic w_signed;
    logic w_a_neg;
    logic w_b_neg;

    // MULT (0) and DIV (2) are the signed encodings.
    assign w_signed   = ~bus.op[0];
    assign w_a_neg    = w_signed & bus.src_a[31];
    assign w_b_neg    = w_signed & bus.src_b[31];
    assign w_abs_a    = w_a_neg ? (32'd0 - bus.src_a) : bus.src_a;
    assign w_abs_b    = w_b_neg ? (32'd0 - bus.src_b) : bus.src_b;
    assign w_neg_q_in = w_a_neg ^ w_b_neg;
    assign w_neg_r_in = w_a_neg;
    assign w_neg_q    = r_neg_q;
    assign w_neg_r    = r_neg_r;

    // Sign flags captured with the operands at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= w_neg_q_in;
            r_neg_r <= w_neg_r_in;
        end
    end
`else
    assign w_abs_a    = bus.src_a;
    assign w_abs_b    = bus.src_b;
    assign w_neg_q_in = 1'b0;
    assign w_neg_r_in = 1'b0;
    assign w_neg_q    = 1'b0;
    assign w_neg_r    = 1'b0;
`endif

    // One iteration of shift-add multiply or restoring divide, plus final sign fix.
    logic [32:0] w_add;
    logic [32:0] w_shift;
    logic [31:0] w_sub;
    logic        w_ge;
    logic [63:0] w_step;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic [63:0] w_prod;

    always_comb begin
        w_add    = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_opnd : 32'd0)};
        w_shift  = r_acc[63:31];
        w_ge     = (w_shift >= {1'b0, r_opnd});
        // When w_ge holds the true difference is below 2^32, so 32 bits suffice.
        w_sub    = w_shift[31:0] - r_opnd;
        w_step   = r_is_div ? {(w_ge ? w_sub : w_shift[31:0]), r_acc[30:0], w_ge}
                            : {w_add, r_acc[31:1]};
        w_prod   = w_neg_q ? (64'd0 - r_acc) : r_acc;
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (r_is_div) begin
            // Divide by zero leaves the dividend in the remainder half, so the
            // sign-corrected remainder equals the captured src_a.
            w_res_hi = w_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
            w_res_lo = r_dbz   ? 32'hFFFF_FFFF
                               : (w_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0]);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_state_next = c_CALC;
            c_CALC: begin
                if (bus.flush)           w_state_next = c_IDLE;
                else if (r_cnt == 5'd31) w_state_next = c_FIX;
            end
            c_FIX:   w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Datapath, HI/LO and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 5'd0;
            r_is_div  <= 1'b0;
            r_dbz     <= 1'b0;
            r_opnd    <= 32'd0;
            r_acc     <= 64'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz_out <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            r_done    <= 1'b0;
            r_dbz_out <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.hi_we) r_hi <= bus.wdata;
                    if (bus.lo_we) r_lo <= bus.wdata;
                    if (w_accept) begin
                        r_is_div <= bus.op[1];
                        r_dbz    <= bus.op[1] && (bus.src_b == 32'd0);
                        r_opnd   <= bus.op[1] ? w_abs_b : w_abs_a;
                        r_acc    <= {32'd0, (bus.op[1] ? w_abs_a : w_abs_b)};
                        r_cnt    <= 5'd0;
                        r_busy   <= 1'b1;
                    end
                end
                c_CALC: begin
                    if (bus.flush) begin
                        r_busy <= 1'b0;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                c_FIX: begin
                    r_busy <= 1'b0;
                    if (!bus.flush) begin
                        r_hi      <= w_res_hi;
                        r_lo      <= w_res_lo;
                        r_done    <= 1'b1;
                        r_dbz_out <= r_dbz;
                    end
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz_out;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule
`default_nettype wire
